ram_stream_reader: RTL and testbench

//  Reader end of the dual-port operand/result RAM. The sequencer writes ALU results into the RAM.

---
 rtl/ram_stream_reader.sv | 176 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams COUNT words from a synchronous-read RAM, starting at BASE.
// Latency: start -> ram_en 1 cycle, first m_valid 3 cycles, 1 word/cycle while m_ready is high.
// Backpressure: 2-entry output buffer. Reads stall while buffered + in-flight words would exceed 2.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start, base_addr, count  launch a transfer; sampled in IDLE only; count==0 gives an empty transfer
//   busy, done               transfer in progress / 1-cycle completion pulse
//   ram_en, ram_addr         read-only RAM port with 1-cycle read latency
//   ram_dout                 RAM read data, valid the cycle after ram_en
//   m_valid, m_data, m_last  output stream; m_last marks word count-1
//   m_ready                  sink handshake input
//   csum                     mod-2^DW sum of the accepted words (only with RAM_STREAM_CHECKSUM_EN)
// Build option: define RAM_STREAM_CHECKSUM_EN to add the csum output and its accumulator.
module ram_stream_reader #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] count,
   output logic          busy,
   output logic          done,
   output logic          ram_en,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_dout,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   input  logic          m_ready
`ifdef RAM_STREAM_CHECKSUM_EN
   ,
   output logic [DW-1:0] csum
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] rd_addr;      // next address to read
   logic [AW-1:0] rd_left;      // reads still to issue
   logic          rd_vld;       // read issued last cycle, so ram_dout is valid now
   logic          rd_last;      // that read was the final word
   logic [DW-1:0] buf0_data, buf1_data;
   logic          buf0_last, buf1_last;
   logic [1:0]    buf_cnt;      // buf0 is the head
   logic          pop, issue, issue_last, done_nxt, accept_start;
   logic [1:0]    occ;

   assign pop          = m_valid & m_ready;
   assign accept_start = (state == IDLE) && start;
   assign m_valid      = (buf_cnt != 2'd0);
   assign m_data       = buf0_data;
   assign m_last       = buf0_last & m_valid;
   assign busy         = (state != IDLE);
   assign ram_en       = issue;
   assign ram_addr     = rd_addr;

   // Buffer occupancy once this cycle's pop and arriving word are applied.
   // A read issued now lands one cycle later, so issuing only while this is
   // below 2 never overflows the buffer. Counting the pop as a credit in the
   // same cycle is what allows back-to-back reads at full rate.
   assign occ = buf_cnt + {1'b0, rd_vld} - {1'b0, pop};

   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      issue_last = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (occ < 2'd2) begin
               issue = 1'b1;
               if (rd_left == AW'(1)) begin
                  issue_last = 1'b1;
                  state_nxt  = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && buf0_last) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         done      <= 1'b0;
         rd_addr   <= '0;
         rd_left   <= '0;
         rd_vld    <= 1'b0;
         rd_last   <= 1'b0;
         buf_cnt   <= 2'd0;
         buf0_data <= '0;
         buf1_data <= '0;
         buf0_last <= 1'b0;
         buf1_last <= 1'b0;
      end else begin
         state   <= state_nxt;
         done    <= done_nxt;
         rd_vld  <= issue;
         rd_last <= issue_last;

         if (accept_start && (count != '0)) begin
            rd_addr <= base_addr;
            rd_left <= count;
         end else if (issue) begin
            rd_addr <= rd_addr + AW'(1);   // wraps at 2^AW
            rd_left <= rd_left - AW'(1);
         end

         case ({pop, rd_vld})
            2'b01: begin
               if (buf_cnt == 2'd0) begin
                  buf0_data <= ram_dout;
                  buf0_last <= rd_last;
               end else begin
                  buf1_data <= ram_dout;
                  buf1_last <= rd_last;
               end
               buf_cnt <= buf_cnt + 2'd1;
            end
            2'b10: begin
               buf0_data <= buf1_data;
               buf0_last <= buf1_last;
               buf_cnt   <= buf_cnt - 2'd1;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  buf0_data <= ram_dout;
                  buf0_last <= rd_last;
               end else begin
                  buf0_data <= buf1_data;
                  buf0_last <= buf1_last;
                  buf1_data <= ram_dout;
                  buf1_last <= rd_last;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RAM_STREAM_CHECKSUM_EN
   logic [DW-1:0] csum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else if (accept_start) begin
         csum_q <= '0;
      end else if (pop) begin
         csum_q <= csum_q + m_data;
      end
   end

   assign csum = csum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;
   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] count;
   logic          busy;
   logic          done;
   logic          ram_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_ready;
`ifdef RAM_STREAM_CHECKSUM_EN
   logic [DW-1:0] csum;
`endif

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] mem [0:255];

   always #5 clk = ~clk;

   // Synchronous-read RAM model
   always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

   ram_stream_reader #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
`ifdef RAM_STREAM_CHECKSUM_EN
      , .csum(csum)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     busy, 0);
      check({tag, "_done"},     done, 0);
      check({tag, "_ram_en"},   ram_en, 0);
      check({tag, "_ram_addr"}, ram_addr, 0);
      check({tag, "_m_valid"},  m_valid, 0);
      check({tag, "_m_data"},   m_data, 0);
      check({tag, "_m_last"},   m_last, 0);
`ifdef RAM_STREAM_CHECKSUM_EN
      check({tag, "_csum"},     csum, 0);
`endif
   endtask

   // Runs one transfer and checks it cycle by cycle against a queue of expected
   // words taken from the RAM model. Cycle 1 is the cycle after start is sampled.
   // rmode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
   // rst_after > 0: reset for one cycle once that many words have been accepted.
   task automatic run_xfer(input logic [7:0] b, input logic [7:0] n, input int rmode,
                           input int mid_start, input int rst_after,
                           output int first_valid, output int done_cyc);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] sum;
      logic [DW-1:0] stall_data;
      logic          stall_last;
      logic          stalled;
      int nn, acc, iss, k, last_hs, max_out, budget;
      bit fin;

      nn = n;
      exp_q = {};
      sum = '0;
      for (int i = 0; i < nn; i++) begin
         exp_q.push_back(mem[8'(b + i)]);
         sum = sum + mem[8'(b + i)];
      end

      start = 1'b1; base_addr = b; count = n; m_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = 8'($urandom);   // must have been latched
      count = 8'($urandom);

      acc = 0; iss = 0; last_hs = -1; max_out = 0; stalled = 1'b0; fin = 1'b0;
      first_valid = 0; done_cyc = 0;
      budget = nn * 8 + 40;
      k = 1;
      while (!fin) begin
         case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((k % 3) == 1);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (mid_start != 0) begin
            start = (k == 2);
            if (k == 2) begin
               base_addr = b + 8'h40;
               count = 8'($urandom_range(1, 255));
            end
         end
         @(negedge clk);

         check("busy", busy, (nn != 0 && acc < nn));
         check("done", done, ((nn == 0 && k == 1) || (nn != 0 && last_hs > 0 && k == last_hs + 1)));
         if (done && done_cyc == 0) done_cyc = k;

         if (ram_en) begin
            check("ram_en_excess", (iss < nn), 1);
            check("ram_addr", ram_addr, 8'(b + iss));
            if (iss == 0) check("first_ram_en_cycle", k, 1);
            iss++;
         end

         if (stalled) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, stall_data);
            check("stall_last", m_last, stall_last);
         end
         stalled = 1'b0;

         if (m_valid) begin
            if (first_valid == 0) first_valid = k;
            check("m_valid_excess", (acc < nn), 1);
            if (acc < nn) begin
               check("m_data", m_data, exp_q[acc]);
               check("m_last", m_last, (acc == nn - 1));
            end
            if (m_ready) begin
               acc++;
               if (acc == nn) last_hs = k;
            end else begin
               stalled = 1'b1;
               stall_data = m_data;
               stall_last = m_last;
            end
         end
         if (iss - acc > max_out) max_out = iss - acc;

         if (rst_after > 0 && acc == rst_after) begin
            @(posedge clk); #1;
            rst = 1'b1; m_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0; m_ready = 1'b1;
            @(negedge clk);
            check_reset_outputs("after_abort");
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check("abort_no_done", done, 0);
               check("abort_no_valid", m_valid, 0);
            end
            @(posedge clk); #1;
            return;
         end

         if (nn == 0 && k >= 3) fin = 1'b1;
         if (nn != 0 && last_hs > 0 && k >= last_hs + 3) fin = 1'b1;
         if (k > budget) begin
            tests++; fails++;
            $display("FAIL timeout: transfer base=%0h count=%0d accepted %0d words, required %0d", b, nn, acc, nn);
            fin = 1'b1;
         end
         @(posedge clk); #1;
         k++;
      end
      m_ready = 1'b0;

      check("outstanding_le_2", (max_out <= 2), 1);
      check("words_accepted", acc, nn);
`ifdef RAM_STREAM_CHECKSUM_EN
      check("csum", csum, sum);
`endif
   endtask

   typedef struct {
      logic [7:0] base;
      logic [7:0] cnt;
      int         rmode;
      int         mid_start;
      int         exp_first;   // first m_valid cycle; 0 = none; -1 = not checked
      int         exp_done;    // done cycle; -1 = not checked
   } vec_t;

   vec_t vecs[7];

   initial begin
      int fv, dc;

      vecs[0] = '{8'h10, 8'd4,   0, 0,  3,   7};    // basic 4-word stream
      vecs[1] = '{8'hFE, 8'd3,   0, 0,  3,   6};    // address wrap FE,FF,00
      vecs[2] = '{8'h40, 8'd5,   1, 0, -1,  -1};    // stalling sink
      vecs[3] = '{8'h55, 8'd0,   0, 0,  0,   1};    // empty transfer
      vecs[4] = '{8'h80, 8'd4,   0, 1,  3,   7};    // start pulsed while busy
      vecs[5] = '{8'hF0, 8'd32,  2, 0, -1,  -1};    // random sink, wrapping
      vecs[6] = '{8'h00, 8'd255, 0, 0,  3, 258};    // maximum length

      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h10] = 16'h0001; mem[8'h11] = 16'h0002;
      mem[8'h12] = 16'h0003; mem[8'h13] = 16'h0004;
      mem[8'hFE] = 16'hAAAA; mem[8'hFF] = 16'hBBBB; mem[8'h00] = 16'hCCCC;

      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++) begin
         run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].rmode, vecs[v].mid_start, 0, fv, dc);
         if (vecs[v].exp_first >= 0) check($sformatf("vec%0d_first_valid", v), fv, vecs[v].exp_first);
         if (vecs[v].exp_done >= 0)  check($sformatf("vec%0d_done_cycle", v), dc, vecs[v].exp_done);
      end

      // Abort after 2 of 6 words, then a fresh transfer must stream cleanly.
      run_xfer(8'h30, 8'd6, 0, 0, 2, fv, dc);
      run_xfer(8'h20, 8'd2, 0, 0, 0, fv, dc);
      check("post_reset_first_valid", fv, 3);
      check("post_reset_done_cycle", dc, 5);

      // Randomized transfers against the queue model.
      for (int r = 0; r < 20; r++) begin
         run_xfer(8'($urandom), 8'($urandom_range(1, 12)), 2, 0, 0, fv, dc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required $finish before it");
      $fatal(1, "watchdog");
   end

endmodule
